// File: rtl/mult16_arbiter.sv
// Round-robin front end sharing one external 16x16 signed multiplier among N_REQ requesters.
// Each requester owns a slot: one op in flight, result held until its own handshake.
//   state | meaning
//   IDLE  | slot free, requester may be granted
//   BUSY  | operands issued, product not yet captured
//   DONE  | product held on res_data, res_valid high
module mult16_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [15:0]           mult_a,
  output logic [15:0]           mult_b,
  output logic                  mult_in_valid,
  input  logic [31:0]           mult_p,
  output logic [N_REQ-1:0]      res_valid,
  input  logic [N_REQ-1:0]      res_ready,
  output logic [32*N_REQ-1:0]   res_data
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} slot_t;

  slot_t             slot_q [N_REQ];
  slot_t             slot_d [N_REQ];
  logic [31:0]       res_q  [N_REQ];
  logic [N_REQ-1:0]  cap_hit;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  grant;
  logic [IW-1:0]     grant_idx;
  logic              found;
  logic [IW:0]       cand_sum;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     issue_idx;
  logic              tag_v   [MULT_LAT];
  logic [IW-1:0]     tag_idx [MULT_LAT];
  logic              cap_valid;
  logic [IW-1:0]     cap_idx;
  logic              accept;

  // Search starts one past the last winner and wraps, so every requester gets a turn.
  always_comb begin
    elig      = '0;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (slot_q[i] == IDLE);
    end
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, last_grant} + (IW+1)'(k + 1);
      if (cand_sum >= N_W) cand_sum = cand_sum - N_W;
      cand = cand_sum[IW-1:0];
      if (!found && elig[cand]) begin
        found       = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  assign req_ready = grant & {N_REQ{sys_rst_n}};
  assign accept    = found;
  assign cap_valid = tag_v[MULT_LAT-1];
  assign cap_idx   = tag_idx[MULT_LAT-1];

  always_comb begin
    res_valid = '0;
    cap_hit   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      slot_d[i]    = slot_q[i];
      res_valid[i] = (slot_q[i] == DONE);
      case (slot_q[i])
        IDLE: if (grant[i]) slot_d[i] = BUSY;
        BUSY: if (cap_valid && (cap_idx == IW'(i))) begin
          cap_hit[i] = 1'b1;
          slot_d[i]  = DONE;
        end
        DONE: if (res_ready[i]) slot_d[i] = IDLE;
        default: slot_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        slot_q[i] <= IDLE;
        res_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        slot_q[i] <= slot_d[i];
        if (cap_hit[i]) res_q[i] <= mult_p;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_grant    <= IW'(N_REQ - 1);
      issue_idx     <= '0;
      mult_in_valid <= 1'b0;
      mult_a        <= '0;
      mult_b        <= '0;
    end else begin
      mult_in_valid <= accept;
      if (accept) begin
        last_grant <= grant_idx;
        issue_idx  <= grant_idx;
        mult_a     <= req_a[int'(grant_idx)*16 +: 16];
        mult_b     <= req_b[int'(grant_idx)*16 +: 16];
      end
    end
  end

  // Tags ride alongside the multiplier so the product lands in the slot that issued it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < MULT_LAT; k++) begin
        tag_v[k]   <= 1'b0;
        tag_idx[k] <= '0;
      end
    end else begin
      tag_v[0]   <= mult_in_valid;
      tag_idx[0] <= issue_idx;
      for (int k = 1; k < MULT_LAT; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_res
    assign res_data[32*g +: 32] = res_q[g];
  end

endmodule

// File: tb/tb_mult16_arbiter.sv
// Self-checking bench: transaction-level model of slots and round-robin order, external
// multiplier emulated as a fixed-latency delay line that emits garbage when idle.
module tb_mult16_arbiter;
  localparam int N_REQ    = 4;
  localparam int MULT_LAT = 2;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic [N_REQ-1:0]     req_valid, req_ready, res_valid, res_ready;
  logic [16*N_REQ-1:0]  req_a, req_b;
  logic [15:0]          mult_a, mult_b;
  logic                 mult_in_valid;
  logic [31:0]          mult_p;
  logic [32*N_REQ-1:0]  res_data;

  int tests = 0;
  int fails = 0;

  mult16_arbiter #(.N_REQ(N_REQ), .MULT_LAT(MULT_LAT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_in_valid(mult_in_valid),
    .mult_p(mult_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 sys_clk = ~sys_clk;

  // external multiplier: product appears exactly MULT_LAT cycles after the issue strobe
  logic [31:0] p_pipe [MULT_LAT];
  always @(posedge sys_clk) begin
    logic signed [31:0] pr;
    pr = $signed(mult_a) * $signed(mult_b);
    for (int k = MULT_LAT-1; k > 0; k--) p_pipe[k] <= p_pipe[k-1];
    p_pipe[0] <= mult_in_valid ? pr : $urandom;
  end
  assign mult_p = p_pipe[MULT_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic        m_busy  [N_REQ];
  int          m_done_at [N_REQ];
  logic [31:0] m_prod  [N_REQ];
  logic [31:0] m_rdata [N_REQ];
  int          m_last;
  logic        m_iv;
  logic [15:0] m_ia, m_ib;
  int          cyc = 0;
  int          n_acc = 0;
  int          live_acc = 0, live_hs = 0;

  always @(negedge sys_clk) begin
    logic [N_REQ-1:0] exp_rv, exp_rdy;
    logic             got;
    int               c;
    logic [15:0]      a, b;
    logic signed [31:0] pr;
    if (!sys_rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        m_busy[i] = 1'b0; m_rdata[i] = '0; m_prod[i] = '0; m_done_at[i] = 0;
      end
      m_last = N_REQ - 1; m_iv = 1'b0; m_ia = '0; m_ib = '0;
      live_acc = 0; live_hs = 0;
    end
    exp_rv = '0;
    for (int i = 0; i < N_REQ; i++) begin
      exp_rv[i] = m_busy[i] && (cyc >= m_done_at[i]);
      if (exp_rv[i]) m_rdata[i] = m_prod[i];
    end
    exp_rdy = '0;
    got = 1'b0;
    if (sys_rst_n) begin
      for (int k = 1; k <= N_REQ; k++) begin
        c = (m_last + k) % N_REQ;
        if (!got && req_valid[c] && !m_busy[c]) begin
          exp_rdy[c] = 1'b1;
          got = 1'b1;
        end
      end
    end
    chk("req_ready", req_ready, exp_rdy);
    chk("ready_onehot", ($countones(req_ready) <= 1), 1'b1);
    chk("mult_in_valid", mult_in_valid, m_iv);
    chk("mult_a", mult_a, m_ia);
    chk("mult_b", mult_b, m_ib);
    chk("res_valid", res_valid, exp_rv);
    for (int i = 0; i < N_REQ; i++) chk($sformatf("res_data[%0d]", i), res_data[32*i +: 32], m_rdata[i]);
    if (sys_rst_n) begin
      for (int i = 0; i < N_REQ; i++)
        if (exp_rv[i] && res_ready[i]) begin m_busy[i] = 1'b0; live_hs++; end
      m_iv = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (exp_rdy[i]) begin
          a = req_a[16*i +: 16];
          b = req_b[16*i +: 16];
          pr = $signed(a) * $signed(b);
          m_busy[i] = 1'b1; m_done_at[i] = cyc + MULT_LAT + 2; m_prod[i] = pr;
          m_iv = 1'b1; m_ia = a; m_ib = b; m_last = i;
          n_acc++; live_acc++;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: rand_opnd = 16'h8000;
      1: rand_opnd = 16'h7FFF;
      2: rand_opnd = 16'h0000;
      default: rand_opnd = 16'($urandom);
    endcase
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N_REQ; i++) begin
      req_a[16*i +: 16] = rand_opnd();
      req_b[16*i +: 16] = rand_opnd();
    end
  endtask

  task automatic do_reset(input logic [N_REQ-1:0] valid_at_release);
    @(posedge sys_clk); #1 sys_rst_n = 1'b0;
    req_valid = valid_at_release;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input string name);
    int n;
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
    req_valid[idx] = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge sys_clk);
      if (req_ready[idx]) break;
    end
    if (n == 20) timeout_fail({name, "_grant"});
    @(posedge sys_clk); #1;
    req_valid[idx] = 1'b0;
    req_a[16*idx +: 16] = 16'($urandom);
    req_b[16*idx +: 16] = 16'($urandom);
    for (n = 0; n < 20; n++) begin
      @(negedge sys_clk);
      if (res_valid[idx]) break;
    end
    if (n == 20) timeout_fail({name, "_result"});
    else chk(name, res_data[32*idx +: 32], exp);
    @(posedge sys_clk); #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, n_iss, start_acc;
    sys_rst_n = 1'b0; req_valid = '0; res_ready = '1; req_a = '0; req_b = '0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // single op 3 * -5
    req_a[15:0] = 16'd3; req_b[15:0] = 16'hFFFB; req_valid = 4'b0001;
    @(posedge sys_clk); #1 req_valid = '0;
    chk("single_issue_valid", mult_in_valid, 1'b1);
    chk("single_mult_a", mult_a, 16'h0003);
    chk("single_mult_b", mult_b, 16'hFFFB);
    repeat (MULT_LAT) @(posedge sys_clk);
    #1 chk("single_rv_early", res_valid[0], 1'b0);
    @(posedge sys_clk);
    #1 chk("single_rv", res_valid[0], 1'b1);
    chk("single_data", res_data[31:0], 32'hFFFFFFF1);
    repeat (3) @(posedge sys_clk);
    #1;

    run_op(1, 16'h8000, 16'h8000, 32'h40000000, "corner_min_min");
    run_op(1, 16'h7FFF, 16'h8000, 32'hC0008000, "corner_max_min");
    run_op(1, 16'h0000, 16'h1234, 32'h00000000, "corner_zero");
    run_op(3, 16'hFFFF, 16'hFFFF, 32'h00000001, "neg1_neg1");

    // all requesters valid from reset release: grants 0,1,2,3 in order
    rand_ops();
    do_reset('1);
    for (int k = 0; k < N_REQ; k++) begin
      @(negedge sys_clk);
      chk($sformatf("rr_order_%0d", k), req_ready, 4'b0001 << k);
      @(posedge sys_clk); #1 rand_ops();
    end
    repeat (40) begin @(posedge sys_clk); #1 rand_ops(); end

    // backpressure on requester 2
    res_ready = 4'b1011;
    for (n = 0; n < 30; n++) begin
      @(negedge sys_clk);
      if (res_valid[2]) break;
    end
    if (n == 30) timeout_fail("bp_wait");
    n_iss = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      chk("bp_res_valid2", res_valid[2], 1'b1);
      chk("bp_res_data2", res_data[95:64], m_prod[2]);
      chk("bp_req_ready2", req_ready[2], 1'b0);
      if (mult_in_valid) n_iss++;
      @(posedge sys_clk); #1 rand_ops();
    end
    chk("bp_others_issue", (n_iss >= 3), 1'b1);
    res_ready = '1;
    repeat (5) @(posedge sys_clk);

    // reset right after issues to requesters 1 and 3
    do_reset('0);
    req_valid = 4'b1010;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    req_valid = '0;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mult_in_valid", mult_in_valid, 1'b0);
    chk("rst_mult_a", mult_a, 16'h0000);
    chk("rst_mult_b", mult_b, 16'h0000);
    chk("rst_res_valid", res_valid, 4'b0000);
    chk("rst_res_data", res_data, 128'h0);
    chk("rst_req_ready", req_ready, 4'b0000);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      chk("post_rst_no_result", res_valid, 4'b0000);
    end

    // random traffic
    start_acc = n_acc;
    n = 0;
    while ((n_acc - start_acc) < 10000 && n < 40000) begin
      @(posedge sys_clk); #1;
      req_valid = 4'($urandom);
      for (int i = 0; i < N_REQ; i++) res_ready[i] = ($urandom_range(0, 3) != 0);
      rand_ops();
      n++;
    end
    @(posedge sys_clk); #1 req_valid = '0; res_ready = '1;
    repeat (MULT_LAT + 6) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("random_ops_done", ((n_acc - start_acc) >= 10000), 1'b1);
    chk("no_lost_or_dup", live_hs, live_acc);
    chk("drained_idle", res_valid, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult16_arbiter.md
MULT16_ARBITER -- requirements
Module: mult16_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one 16x16 signed Booth-4/Wallace multiplier (legal values 2..8).
REQ-002 Parameter MULT_LAT, default 2: fixed multiplier latency in cycles from mult_in_valid to mult_p valid (legal values 1..4).
REQ-003 sys_clk  in  1  the block's only clock; all state updates on the rising edge.
REQ-004 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  N_REQ  per-requester operand valid.
REQ-006 req_ready  out  N_REQ  per-requester operand accept; at most one bit high per cycle.
REQ-007 req_a  in  16*N_REQ  signed multiplicands; slice i is [16i+15:16i].
REQ-008 req_b  in  16*N_REQ  signed multipliers; same slicing as req_a.
REQ-009 mult_a  out  16  registered operand A to the multiplier.
REQ-010 mult_b  out  16  registered operand B to the multiplier.
REQ-011 mult_in_valid  out  1  registered issue strobe.
REQ-012 mult_p  in  32  signed product, valid exactly MULT_LAT cycles after mult_in_valid.
REQ-013 res_valid  out  N_REQ  per-requester result valid.
REQ-014 res_ready  in  N_REQ  per-requester result accept.
REQ-015 res_data  out  32*N_REQ  per-requester product; slice i is [32i+31:32i].

Function
REQ-016 Each requester has its own slot FSM with states IDLE, BUSY (op in flight) and DONE (result held).
REQ-017 Slot transitions: IDLE->BUSY on accept; BUSY->DONE on result capture; DONE->IDLE on res_valid[i]&res_ready[i].
REQ-018 A slot returning to IDLE is not eligible for grant in the same cycle; it is eligible from the next cycle.
REQ-019 Eligible requester i: req_valid[i]=1 and slot i IDLE.
REQ-020 Arbitration is combinational round-robin, searching from index (last_grant+1) mod N_REQ upward with wrap-around.
REQ-021 req_ready[i]=1 only for the single winning eligible requester; all req_ready bits are 0 when no requester is eligible.
REQ-022 Accept = req_valid[i]&req_ready[i]; on accept, last_grant<=i. last_grant is unchanged in cycles with no accept.
REQ-023 If accept occurs in cycle T: mult_a/mult_b take slice i in cycle T+1, mult_in_valid=1 in T+1, otherwise mult_in_valid=0.
REQ-024 mult_a/mult_b hold their last value when mult_in_valid=0.
REQ-025 A tag pipeline of depth MULT_LAT carries {valid, requester index} alongside each issue.
REQ-026 The tag emerging at T+1+MULT_LAT samples mult_p into res_data slice i; res_valid[i]=1 from cycle T+2+MULT_LAT.
REQ-027 Accept-to-res_valid latency is therefore MULT_LAT+2 cycles.
REQ-028 Throughput: one issue per cycle when distinct requesters are eligible; at most one op in flight per requester.
REQ-029 res_data slice i is stable while res_valid[i]=1; res_ready[i] with res_valid[i]=0 has no effect.
REQ-030 Products are 32-bit two's complement: (-32768)*(-32768) = 0x40000000 and 0x7FFF*0x8000 = 0xC0008000.
REQ-031 A capture and a res handshake on different slots in the same cycle are both honoured.
REQ-032 Inputs req_a/req_b are sampled only in the accept cycle; later changes do not affect the op.

Reset
REQ-033 sys_rst_n=0 asynchronously forces: all slots IDLE, last_grant=N_REQ-1 (first search starts at 0), tag pipeline invalid, mult_in_valid=0, mult_a=mult_b=0, res_valid=0, res_data=0.
REQ-034 While reset is asserted, req_ready=0.
REQ-035 A reset mid-operation discards all in-flight ops; mult_p returning after reset release is ignored.
REQ-036 After reset release, the first accept is possible in the first clock edge with sys_rst_n=1.

Verification
REQ-037 Single op: req 0 valid with a=3, b=-5 at T -> mult_in_valid at T+1, res_valid[0]=1 at T+MULT_LAT+2, res_data[0]=0xFFFFFFF1.
REQ-038 All 4 requesters valid continuously after reset with res_ready=all-1 -> grant order 0,1,2,3, then 0 is re-granted no earlier than one cycle after its result handshake; products are correct.
REQ-039 Backpressure: req 2 completes with res_ready[2]=0 for 10 cycles -> res_valid[2] and res_data held constant, req_ready[2]=0 throughout, other requesters keep issuing.
REQ-040 Corner operands: (-32768,-32768) -> 0x40000000; (32767,-32768) -> 0xC0008000; (0,x) -> 0.
REQ-041 Reset asserted one cycle after issues to requesters 1 and 3 -> all outputs zero immediately; no res_valid after release until a new accept.
REQ-042 Random traffic, 10k ops, MULT_LAT in {1,2,4} -> scoreboard matches a*b per requester, in-order per requester; no lost or duplicated result; at most one req_ready bit high in any cycle.
